// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that serialises multi-byte words from NUM_REQ requesters
// into a single UART transmitter, optionally prefixing each word with an ID header.
module uart_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_BYTES = 4,
  parameter int HEADER_EN  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*WORD_BYTES*8-1:0] req_data,
  output logic [NUM_REQ-1:0]              ack,
  output logic                            uart_transmit,
  output logic [7:0]                      uart_tx_byte,
  input  logic                            uart_is_transmitting,
  output logic                            busy,
  output logic [3:0]                      grant_id
);

  localparam int                WW        = WORD_BYTES * 8;
  localparam int                CNT_W     = 5;
  localparam logic [CNT_W-1:0]  NBYTES    = CNT_W'(WORD_BYTES + HEADER_EN);
  localparam logic [3:0]        LAST_INIT = 4'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PULSE, S_HOLD} state_t;

  state_t               state_q;
  logic [3:0]           last_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WW-1:0]        shift_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 transmit_q;
  logic [7:0]           tx_byte_q;
  logic                 busy_q;
  logic [3:0]           gid_q;

  logic                 pick_vld_d;
  logic [3:0]           pick_id_d;
  logic [WW-1:0]        pick_word_d;

  // Search starts one past the last winner, so every requester waits at most NUM_REQ-1 words.
  always_comb begin
    pick_vld_d  = 1'b0;
    pick_id_d   = '0;
    pick_word_d = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!pick_vld_d && req[j] && (j == (int'(last_q) + i) % NUM_REQ)) begin
          pick_vld_d  = 1'b1;
          pick_id_d   = 4'(j);
          pick_word_d = req_data[j*WW +: WW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= LAST_INIT;
      cnt_q      <= '0;
      shift_q    <= '0;
      ack_q      <= '0;
      transmit_q <= 1'b0;
      tx_byte_q  <= '0;
      busy_q     <= 1'b0;
      gid_q      <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            gid_q   <= pick_id_d;
            last_q  <= pick_id_d;
            ack_q   <= NUM_REQ'(1) << pick_id_d;
            cnt_q   <= NBYTES;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
            if (HEADER_EN != 0) begin
              tx_byte_q <= {4'hA, pick_id_d};
              shift_q   <= pick_word_d;
            end else begin
              tx_byte_q <= pick_word_d[WW-1 -: 8];
              shift_q   <= pick_word_d << 8;
            end
          end
        end
        S_WAIT: begin
          if (!uart_is_transmitting) state_q <= S_PULSE;
        end
        S_PULSE: begin
          transmit_q <= 1'b1;
          state_q    <= S_HOLD;
        end
        S_HOLD: begin
          // The UART needs transmit low for a cycle before it will accept the next byte.
          transmit_q <= 1'b0;
          cnt_q      <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tx_byte_q <= shift_q[WW-1 -: 8];
            shift_q   <= shift_q << 8;
            state_q   <= S_WAIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack           = ack_q;
  assign uart_transmit = transmit_q;
  assign uart_tx_byte  = tx_byte_q;
  assign busy          = busy_q;
  assign grant_id      = gid_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: a UART model checks every byte, grant and pulse timing.
module tb_uart_tx_scheduler;
  localparam int NR = 4;
  localparam int WB = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*WB*8-1:0] req_data;
  logic [NR-1:0]    ack;
  logic             uart_transmit;
  logic [7:0]       uart_tx_byte;
  logic             is_tx;
  logic             busy;
  logic [3:0]       gid;

  logic [NR-1:0]    req2;
  logic [NR*8-1:0]  req_data2;
  logic [NR-1:0]    ack2;
  logic             uart_transmit2;
  logic [7:0]       uart_tx_byte2;
  logic             is_tx2;
  logic             busy2;
  logic [3:0]       gid2;

  logic [31:0] word_tab [NR];
  logic [7:0]  exp_q [$];
  int          exp_gid [$];
  logic [7:0]  exp2_q [$];

  int total = 0;
  int bad   = 0;
  int cyc = 0, cnt = 0, hold_len = 3, fall_cyc = 0, obs_cnt = 0, pulses2 = 0, gaps = 0;
  bit fall_ok = 1'b0, meas_en = 1'b0, prev_tx = 1'b0;
  int reraise [NR];
  bit pend [NR];

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int r = 0; r < NR; r++) req_data[r*32 +: 32] = word_tab[r];
  end

  uart_tx_scheduler #(.NUM_REQ(NR), .WORD_BYTES(WB), .HEADER_EN(1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(is_tx), .busy(busy), .grant_id(gid)
  );

  uart_tx_scheduler #(.NUM_REQ(NR), .WORD_BYTES(1), .HEADER_EN(0)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .req_data(req_data2), .ack(ack2),
    .uart_transmit(uart_transmit2), .uart_tx_byte(uart_tx_byte2),
    .uart_is_transmitting(is_tx2), .busy(busy2), .grant_id(gid2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input int r, input logic [31:0] w);
    exp_gid.push_back(r);
    exp_q.push_back({4'hA, 4'(r)});
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endtask

  // One clock: UART model, requester agents and scoreboard run at the falling edge.
  task automatic tick();
    int g;
    @(negedge clk);
    cyc++;
    if (!rst && uart_transmit) begin
      check("tx_while_busy", 32'(is_tx), 0);
      check("pulse_width", 32'(prev_tx), 0);
      obs_cnt++;
      if (exp_q.size() == 0) check("byte_extra", 32'(exp_q.size()), 1);
      else check("byte", uart_tx_byte, exp_q.pop_front());
      if (meas_en && fall_ok) begin
        check("gap_after_fall", cyc - fall_cyc, 2);
        gaps++;
      end
      fall_ok = 1'b0;
      cnt = hold_len;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        fall_cyc = cyc;
        fall_ok  = 1'b1;
      end
    end
    is_tx   = (cnt != 0);
    prev_tx = uart_transmit;
    if (!rst && ack != 0) begin
      if (exp_gid.size() == 0) check("ack_extra", 32'(ack), 0);
      else begin
        g = exp_gid.pop_front();
        check("ack_onehot", 32'(ack), 32'(1) << g);
        check("grant_id", 32'(gid), g);
      end
    end
    for (int r = 0; r < NR; r++) begin
      if (ack[r]) begin
        req[r] = 1'b0;
        if (reraise[r] > 0) begin
          reraise[r]--;
          pend[r] = 1'b1;
          word_tab[r] += 32'h0101_0101;
        end
      end else if (pend[r]) begin
        req[r]  = 1'b1;
        pend[r] = 1'b0;
      end
    end
    if (!rst && uart_transmit2) begin
      pulses2++;
      if (exp2_q.size() == 0) check("t6_byte_extra", 32'(exp2_q.size()), 1);
      else check("t6_byte", uart_tx_byte2, exp2_q.pop_front());
    end
    if (!rst && ack2 != 0) begin
      check("t6_ack", 32'(ack2), 32'b0010);
      req2 = req2 & ~ack2;
    end
    #1;
  endtask

  function automatic bit all_idle();
    bit p = 1'b0;
    for (int r = 0; r < NR; r++) p |= pend[r];
    return exp_q.size() == 0 && exp_gid.size() == 0 && !busy && req == 0 && !p
           && exp2_q.size() == 0 && !busy2 && req2 == 0 && !is_tx;
  endfunction

  task automatic wait_done(input int budget);
    int n = 0;
    while (n < budget && !all_idle()) begin
      tick();
      n++;
    end
    if (n >= budget) check("timeout", n, 0);
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int n = 0;
    while (n < budget && obs_cnt < target) begin
      tick();
      n++;
    end
    if (n >= budget) check("byte_wait_timeout", n, 0);
  endtask

  initial begin
    rst = 1'b1; req = '0; req2 = '0; is_tx = 1'b0; is_tx2 = 1'b0;
    req_data2 = {8'h11, 8'h22, 8'h5A, 8'h33};
    for (int r = 0; r < NR; r++) begin
      word_tab[r] = '0; reraise[r] = 0; pend[r] = 1'b0;
    end
    repeat (2) tick();
    check("rst_ack", 32'(ack), 0);
    check("rst_transmit", 32'(uart_transmit), 0);
    check("rst_tx_byte", 32'(uart_tx_byte), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(gid), 0);
    rst = 1'b0;
    tick();

    // Single word with header, UART idle.
    word_tab[0] = 32'hDEADBEEF;
    push_word(0, 32'hDEADBEEF);
    req[0] = 1'b1;
    tick(); check("t1_ack_latency", 32'(ack), 32'b0001);
    tick(); check("t1_tx_early", 32'(uart_transmit), 0);
    tick(); check("t1_tx_latency", 32'(uart_transmit), 1);
    wait_bytes(5, 200);
    check("t1_busy_last", 32'(busy), 1);
    tick(); check("t1_busy_end", 32'(busy), 0);
    wait_done(200);

    // All four requesting from reset: served 0,1,2,3.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int r = 0; r < NR; r++) begin
      word_tab[r] = 32'h0102_0304 + 32'h1010_1010 * r;
      push_word(r, word_tab[r]);
    end
    req = 4'b1111;
    wait_done(500);

    // Two requesters re-raising after every ack alternate 1,2,1,2,1,2.
    word_tab[1] = 32'h2122_2324; word_tab[2] = 32'h3132_3334;
    for (int k = 0; k < 3; k++) begin
      push_word(1, 32'h2122_2324 + 32'h0101_0101 * k);
      push_word(2, 32'h3132_3334 + 32'h0101_0101 * k);
    end
    reraise[1] = 2; reraise[2] = 2;
    req[1] = 1'b1; req[2] = 1'b1;
    wait_done(1000);

    // Slow UART: each pulse must follow the busy fall by exactly two cycles.
    hold_len = 1000; meas_en = 1'b1; fall_ok = 1'b0; gaps = 0;
    word_tab[2] = 32'h4142_4344;
    push_word(2, 32'h4142_4344);
    req[2] = 1'b1;
    wait_done(20000);
    check("t4_gap_count", gaps, 4);
    meas_en = 1'b0; hold_len = 3;

    // Reset in the middle of the third byte, then a fresh request from requester 3.
    word_tab[0] = 32'h5152_5354;
    push_word(0, 32'h5152_5354);
    req[0] = 1'b1;
    wait_bytes(obs_cnt + 3, 300);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_transmit", 32'(uart_transmit), 0);
    check("t5_rst_tx_byte", 32'(uart_tx_byte), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_grant_id", 32'(gid), 0);
    check("t5_rst_ack", 32'(ack), 0);
    exp_q.delete(); exp_gid.delete(); req = '0;
    for (int r = 0; r < NR; r++) begin reraise[r] = 0; pend[r] = 1'b0; end
    tick();
    rst = 1'b0;
    tick();
    word_tab[3] = 32'h6162_6364;
    push_word(3, 32'h6162_6364);
    req[3] = 1'b1;
    wait_done(2000);

    // Headerless single-byte configuration.
    pulses2 = 0;
    exp2_q.push_back(8'h5A);
    req2[1] = 1'b1;
    wait_done(100);
    repeat (5) tick();
    check("t6_pulse_count", pulses2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
